// File: rtl/bsg_manycore_pkt_endpoint_decode.sv
// Tile endpoint packet decoder: buffers incoming network packets in a small
// FIFO and decodes the head in order. Remote stores go to the core over a
// valid/yumi handshake. Config packets set the freeze state. Anything else is
// dropped and counted.
module bsg_manycore_pkt_endpoint_decode #(
    parameter int x_cord_width_p = 5,
    parameter int y_cord_width_p = 5,
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 32,
    parameter int op_width_p     = 6,
    parameter int fifo_els_p     = 4,
    parameter int count_width_p  = 8,
    parameter bit freeze_init_p  = 1'b1,
    localparam int packet_width_lp = op_width_p + addr_width_p + data_width_p
                                     + 2 * (x_cord_width_p + y_cord_width_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [packet_width_lp-1:0] data_i,
    output logic                       ready_o,
    output logic                       store_v_o,
    output logic [data_width_p-1:0]    store_data_o,
    output logic [addr_width_p-1:0]    store_addr_o,
    output logic [y_cord_width_p-1:0]  store_from_y_cord_o,
    output logic [x_cord_width_p-1:0]  store_from_x_cord_o,
    input  logic                       store_yumi_i,
    output logic                       freeze_o,
    output logic                       unknown_v_o,
    output logic [count_width_p-1:0]   unknown_count_o
);

    localparam int ptr_w_lp = $clog2(fifo_els_p);

    // Field positions inside a packet, LSB first
    localparam int fx_lo_lp   = x_cord_width_p + y_cord_width_p;
    localparam int fy_lo_lp   = fx_lo_lp + x_cord_width_p;
    localparam int data_lo_lp = 2 * (x_cord_width_p + y_cord_width_p);
    localparam int addr_lo_lp = data_lo_lp + data_width_p;
    localparam int op_lo_lp   = addr_lo_lp + addr_width_p;

    localparam logic [op_width_p-1:0] op_store_lp = op_width_p'(1);
    localparam logic [op_width_p-1:0] op_cfg_lp   = op_width_p'(2);

    logic [packet_width_lp-1:0] mem_q [fifo_els_p];
    logic [ptr_w_lp-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ptr_w_lp:0]          count_q, count_d;
    logic                       freeze_q, freeze_d;
    logic [count_width_p-1:0]   unknown_count_q, unknown_count_d;

    logic                       full, empty, enq, deq;
    logic                       head_store, head_cfg, head_unknown;
    logic [packet_width_lp-1:0] head_pkt;
    logic [op_width_p-1:0]      head_op;
    logic [addr_width_p-1:0]    head_addr;

    assign full     = (count_q == (ptr_w_lp + 1)'(fifo_els_p));
    assign empty    = (count_q == '0);
    assign ready_o  = reset_n_i & ~full;
    assign enq      = v_i & ready_o;
    assign head_pkt = mem_q[rptr_q];

    assign head_op   = head_pkt[op_lo_lp +: op_width_p];
    assign head_addr = head_pkt[addr_lo_lp +: addr_width_p];

    assign store_data_o        = head_pkt[data_lo_lp +: data_width_p];
    assign store_addr_o        = head_addr;
    assign store_from_y_cord_o = head_pkt[fy_lo_lp +: y_cord_width_p];
    assign store_from_x_cord_o = head_pkt[fx_lo_lp +: x_cord_width_p];

    // Classify the FIFO head; an empty FIFO produces no strobes at all
    always_comb begin
        head_store   = 1'b0;
        head_cfg     = 1'b0;
        head_unknown = 1'b0;
        if (!empty) begin
            if (head_op == op_store_lp) begin
                head_store = 1'b1;
            end else if ((head_op == op_cfg_lp) && (head_addr[addr_width_p-1:1] == '0)) begin
                head_cfg = 1'b1;
            end else begin
                head_unknown = 1'b1;
            end
        end
    end

    assign store_v_o       = head_store;
    assign unknown_v_o     = head_unknown;
    assign freeze_o        = freeze_q;
    assign unknown_count_o = unknown_count_q;

    // Stores wait for yumi; config and unknown packets leave after one cycle
    assign deq = (head_store & store_yumi_i) | head_cfg | head_unknown;

    // Next-state for pointers, occupancy, freeze and the saturating counter
    always_comb begin
        wptr_d          = wptr_q;
        rptr_d          = rptr_q;
        count_d         = count_q;
        freeze_d        = freeze_q;
        unknown_count_d = unknown_count_q;
        if (enq) begin
            wptr_d = wptr_q + ptr_w_lp'(1);
        end
        if (deq) begin
            rptr_d = rptr_q + ptr_w_lp'(1);
        end
        if (enq && !deq) begin
            count_d = count_q + (ptr_w_lp + 1)'(1);
        end else if (!enq && deq) begin
            count_d = count_q - (ptr_w_lp + 1)'(1);
        end
        if (head_cfg) begin
            freeze_d = head_addr[0];
        end
        if (head_unknown && (unknown_count_q != '1)) begin
            unknown_count_d = unknown_count_q + count_width_p'(1);
        end
    end

    // Control state register; reset drops every buffered packet
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            freeze_q        <= freeze_init_p;
            unknown_count_q <= '0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            freeze_q        <= freeze_d;
            unknown_count_q <= unknown_count_d;
        end
    end

    // Packet storage needs no reset; validity is tracked by the occupancy count
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_bsg_manycore_pkt_endpoint_decode.sv
// Self-checking bench for bsg_manycore_pkt_endpoint_decode: a queue-based
// reference model is compared on every falling edge, alongside directed
// literal expectations for the main scenarios.
module tb_bsg_manycore_pkt_endpoint_decode;

    localparam int XW = 5;
    localparam int YW = 5;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int OW = 6;
    localparam int FE = 4;
    localparam int CW = 8;
    localparam int PW = OW + AW + DW + 2 * (XW + YW);
    localparam int CMAX = (1 << CW) - 1;

    typedef logic [PW-1:0] pkt_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          v_i;
    pkt_t          data_i;
    logic          ready_o;
    logic          store_v_o;
    logic [DW-1:0] store_data_o;
    logic [AW-1:0] store_addr_o;
    logic [YW-1:0] store_from_y_cord_o;
    logic [XW-1:0] store_from_x_cord_o;
    logic          store_yumi_i;
    logic          freeze_o;
    logic          unknown_v_o;
    logic [CW-1:0] unknown_count_o;

    int totalChecks = 0;
    int badChecks   = 0;

    pkt_t modelQ[$];
    bit   modelFreeze = 1'b1;
    int   modelCount  = 0;

    always #5 clk = ~clk;

    bsg_manycore_pkt_endpoint_decode #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
        .addr_width_p(AW), .op_width_p(OW), .fifo_els_p(FE),
        .count_width_p(CW), .freeze_init_p(1'b1)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .v_i(v_i),
        .data_i(data_i),
        .ready_o(ready_o),
        .store_v_o(store_v_o),
        .store_data_o(store_data_o),
        .store_addr_o(store_addr_o),
        .store_from_y_cord_o(store_from_y_cord_o),
        .store_from_x_cord_o(store_from_x_cord_o),
        .store_yumi_i(store_yumi_i),
        .freeze_o(freeze_o),
        .unknown_v_o(unknown_v_o),
        .unknown_count_o(unknown_count_o)
    );

    // Build a packet from its fields; destination coordinates are left zero
    function automatic pkt_t mkPkt(int unsigned op, logic [31:0] addr, logic [31:0] data,
                                   int unsigned fy, int unsigned fx);
        pkt_t p;
        p = (pkt_t'(op)   << (PW - OW))
          | (pkt_t'(addr) << (DW + 2 * (XW + YW)))
          | (pkt_t'(data) << (2 * (XW + YW)))
          | (pkt_t'(fy)   << (2 * XW + YW))
          | (pkt_t'(fx)   << (XW + YW));
        return p;
    endfunction

    function automatic int unsigned opOf(pkt_t p);
        return int'((p >> (PW - OW)) % (1 << OW));
    endfunction

    function automatic logic [31:0] addrOf(pkt_t p);
        return 32'(p >> (DW + 2 * (XW + YW)));
    endfunction

    function automatic logic [31:0] dataOf(pkt_t p);
        return 32'(p >> (2 * (XW + YW)));
    endfunction

    function automatic int unsigned fyOf(pkt_t p);
        return int'((p >> (2 * XW + YW)) % (1 << YW));
    endfunction

    function automatic int unsigned fxOf(pkt_t p);
        return int'((p >> (XW + YW)) % (1 << XW));
    endfunction

    function automatic bit isStore(pkt_t p);
        return opOf(p) == 1;
    endfunction

    function automatic bit isCfg(pkt_t p);
        return (opOf(p) == 2) && ((addrOf(p) >> 1) == 0);
    endfunction

    task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(logic v, pkt_t d, logic y);
        v_i          = v;
        data_i       = d;
        store_yumi_i = y;
        @(posedge clk);
        #1;
        v_i          = 1'b0;
        data_i       = '0;
        store_yumi_i = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: a packet queue whose head is retired by the decode rules
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            modelQ.delete();
            modelFreeze = 1'b1;
            modelCount  = 0;
        end else begin
            bit   acc;
            pkt_t h;
            acc = v_i && (modelQ.size() < FE);
            if (modelQ.size() > 0) begin
                h = modelQ[0];
                if (isStore(h)) begin
                    if (store_yumi_i) void'(modelQ.pop_front());
                end else if (isCfg(h)) begin
                    modelFreeze = (addrOf(h) % 2) == 1;
                    void'(modelQ.pop_front());
                end else begin
                    if (modelCount < CMAX) modelCount++;
                    void'(modelQ.pop_front());
                end
            end
            if (acc) modelQ.push_back(data_i);
        end
    end

    // Compare DUT outputs against the model in the middle of every cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            checkOutput("rst_ready", ready_o, 0);
            checkOutput("rst_store_v", store_v_o, 0);
            checkOutput("rst_unknown_v", unknown_v_o, 0);
            checkOutput("rst_count", unknown_count_o, 0);
            checkOutput("rst_freeze", freeze_o, 1);
        end else begin
            bit expStore;
            bit expUnk;
            expStore = (modelQ.size() > 0) && isStore(modelQ[0]);
            expUnk   = (modelQ.size() > 0) && !isStore(modelQ[0]) && !isCfg(modelQ[0]);
            checkOutput("m_ready", ready_o, (modelQ.size() < FE) ? 1 : 0);
            checkOutput("m_store_v", store_v_o, expStore);
            checkOutput("m_unknown_v", unknown_v_o, expUnk);
            checkOutput("m_freeze", freeze_o, modelFreeze);
            checkOutput("m_count", unknown_count_o, modelCount);
            if (expStore) begin
                checkOutput("m_store_data", store_data_o, dataOf(modelQ[0]));
                checkOutput("m_store_addr", store_addr_o, addrOf(modelQ[0]));
                checkOutput("m_store_fy", store_from_y_cord_o, fyOf(modelQ[0]));
                checkOutput("m_store_fx", store_from_x_cord_o, fxOf(modelQ[0]));
            end
            if (store_yumi_i) begin
                checkOutput("yumi_legal", store_v_o, 1);
            end
        end
    end

    initial begin
        pkt_t st;
        reset_n      = 1'b1;
        v_i          = 1'b0;
        data_i       = '0;
        store_yumi_i = 1'b0;
        #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #3;
        checkOutput("init_ready", ready_o, 1);
        checkOutput("init_freeze", freeze_o, 1);
        checkOutput("init_store_v", store_v_o, 0);
        checkOutput("init_count", unknown_count_o, 0);

        // Unfreeze config: accepted at edge N, takes effect at edge N+1
        applyStimulus(1'b1, mkPkt(2, 32'h0, 32'h0, 0, 0), 1'b0);
        checkOutput("cfg_freeze_pending", freeze_o, 1);
        idle(1);
        checkOutput("cfg_unfrozen", freeze_o, 0);

        // Single store held for five cycles, then consumed
        st = mkPkt(1, 32'h40, 32'hDEADBEEF, 2, 3);
        applyStimulus(1'b1, st, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_store_v", store_v_o, 1);
            checkOutput("hold_data", store_data_o, 32'hDEADBEEF);
            checkOutput("hold_addr", store_addr_o, 32'h40);
            checkOutput("hold_fx", store_from_x_cord_o, 3);
            checkOutput("hold_fy", store_from_y_cord_o, 2);
            idle(1);
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("store_consumed", store_v_o, 0);

        // Fill the FIFO, try a fifth packet, then drain in order
        for (int i = 0; i < FE; i++) begin
            applyStimulus(1'b1, mkPkt(1, 32'h100 + i, 32'h1000 + i, 0, i), 1'b0);
        end
        checkOutput("full_ready", ready_o, 0);
        applyStimulus(1'b1, mkPkt(1, 32'h200, 32'h5555, 0, 0), 1'b0);
        checkOutput("full_still", ready_o, 0);
        checkOutput("full_head", store_data_o, 32'h1000);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("deq_ready", ready_o, 1);
        checkOutput("order_second", store_data_o, 32'h1001);
        for (int i = 0; i < FE - 1; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput("drained", store_v_o, 0);

        // Freeze config stuck behind a stalled store
        applyStimulus(1'b1, mkPkt(1, 32'h300, 32'hA5A5A5A5, 1, 1), 1'b0);
        applyStimulus(1'b1, mkPkt(2, 32'h1, 32'h0, 0, 0), 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("freeze_blocked", freeze_o, 0);
            idle(1);
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("freeze_after_yumi", freeze_o, 0);
        idle(1);
        checkOutput("freeze_set", freeze_o, 1);

        // 300 unknown packets back to back; counter must saturate
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) st = mkPkt(5, 32'(i), 32'(i), 0, 0);
            else            st = mkPkt(2, 32'h4, 32'(i), 0, 0);
            applyStimulus(1'b1, st, 1'b0);
            if (i == 0) checkOutput("unk_first_pulse", unknown_v_o, 1);
        end
        idle(2);
        checkOutput("unk_saturated", unknown_count_o, 255);
        checkOutput("unk_freeze_kept", freeze_o, 1);
        checkOutput("unk_quiet", unknown_v_o, 0);

        // Reset with three stores buffered
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, mkPkt(1, 32'h500 + i, 32'h7000 + i, 0, 0), 1'b0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_store_v", store_v_o, 0);
        checkOutput("midrst_ready", ready_o, 0);
        checkOutput("midrst_count", unknown_count_o, 0);
        checkOutput("midrst_freeze", freeze_o, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #3;
        checkOutput("post_rst_ready", ready_o, 1);
        checkOutput("post_rst_store_v", store_v_o, 0);
        idle(3);
        checkOutput("no_stale_store", store_v_o, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_pkt_endpoint_decode.md
Name: bsg_manycore_pkt_endpoint_decode

Overview:
Buffered, parametrised packet decoder for a manycore tile endpoint.
- Accepts network packets into a small FIFO and decodes them in order.
- Presents remote stores to the core over a valid/yumi handshake.
- Absorbs configuration packets (freeze/unfreeze) into a registered freeze state.
- Counts malformed or unknown packets.
- Sits between the tile's network input link and the core's remote-store port.

Parameters:
x_cord_width_p, 5, X coordinate width
y_cord_width_p, 5, Y coordinate width
data_width_p, 32, store data width
addr_width_p, 32, word address width (>=2)
op_width_p, 6, opcode field width (>=2)
fifo_els_p, 4, input FIFO depth; power of 2, >=2
count_width_p, 8, unknown-packet counter width
freeze_init_p, 1, freeze_o value after reset
packet_width_lp, op_width_p+addr_width_p+data_width_p+2*(x_cord_width_p+y_cord_width_p), derived packet width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
v_i  in  1  input packet valid
data_i  in  packet_width_lp  packet; MSB..LSB = {op, addr, data, from_y_cord, from_x_cord, y_cord, x_cord}
ready_o  out  1  FIFO can accept; transfer when v_i & ready_o
store_v_o  out  1  remote store at FIFO head
store_data_o  out  data_width_p  store data
store_addr_o  out  addr_width_p  store address
store_from_y_cord_o  out  y_cord_width_p  sender Y
store_from_x_cord_o  out  x_cord_width_p  sender X
store_yumi_i  in  1  core consumes store this cycle; legal only when store_v_o
freeze_o  out  1  registered freeze state
unknown_v_o  out  1  one-cycle pulse: unknown packet discarded
unknown_count_o  out  count_width_p  saturating count of unknown packets

Behaviour:
- Reset (asserted asynchronously, released synchronously by the user):
  - FIFO empty; ready_o=0 while reset is asserted, 1 in the first cycle after release.
  - store_v_o=0, unknown_v_o=0, unknown_count_o=0, freeze_o=freeze_init_p.
  - Reset mid-operation discards all buffered packets.
- FIFO:
  - ready_o = not full; no enqueue-when-full bypass, even if a dequeue happens the same cycle.
  - Enqueue and dequeue in the same cycle are permitted when not full; occupancy is unchanged.
  - Pointers wrap modulo fifo_els_p.
  - Latency: a packet accepted at edge N appears at the head after edge N (outputs valid in cycle N+1).
  - Empty: head decode is inactive and all strobes are 0.
- Head decode, in strict FIFO order (a later packet never overtakes a stalled store):
  - op==1, remote store:
    - store_v_o=1; store_*_o are driven from the head fields.
    - Held stable until store_yumi_i; the head dequeues on the store_yumi_i edge.
  - op==2, config, with addr[addr_width_p-1:1]==0:
    - Dequeued the same cycle it reaches the head.
    - freeze_o <= addr[0] at that edge (1=freeze, 0=unfreeze); idempotent if the value is unchanged.
  - Any other op, or op==2 with nonzero upper address bits:
    - Dequeued the same cycle it reaches the head.
    - unknown_v_o=1 for that cycle (combinational from the head).
    - unknown_count_o increments at that edge, saturating at all-ones.
- Stores are delivered regardless of freeze_o, so a program can be loaded while frozen. freeze_o only informs the core.
- Config and unknown packets each consume one cycle at the head; back-to-back packets of these kinds drain at one per cycle.
- store_yumi_i while store_v_o=0 is illegal: the design ignores it and the bench flags it.
- data_i fields y_cord/x_cord are not checked (routing has already delivered the packet).

Test Plan:
- Reset release with freeze_init_p=1 -> freeze_o=1, ready_o=1, store_v_o=0, unknown_count_o=0; cfg (op=2, addr=0) accepted at edge N -> freeze_o=0 after edge N+1.
- Store op=1 addr=0x40 data=0xDEADBEEF from (x=3,y=2), store_yumi_i held 0 for 5 cycles -> store_v_o=1 with stable fields for all 5; yumi pulse -> dequeue, store_v_o=0 next cycle.
- Enqueue 4 stores with store_yumi_i=0 (fifo_els_p=4) -> ready_o=0 after the 4th; a 5th v_i is not accepted; one yumi -> ready_o=1 next cycle; order preserved.
- Store then cfg freeze (addr=1) queued, yumi delayed 3 cycles -> freeze_o stays 0 until the cycle after the store's yumi.
- op=5, then op=2 with addr=0x4, 300 unknown packets total (count_width_p=8) -> unknown_v_o pulses per packet, freeze_o unchanged, count saturates at 255.
- Assert reset_n_i mid-stream with 3 packets buffered -> outputs return to reset values immediately; no stale store appears after release.
